// File: rtl/sample_buf_ctrl_pkg.sv
// Shared definitions for the ping-pong sample buffer controller.
// Optional feature macro: SAMPLE_BUF_OVF_CNT_EN (overflow counter).
package sample_buf_ctrl_pkg;

  localparam int ADDR_W_DEF  = 10;
  localparam int DATA_W_DEF  = 16;
  localparam int OFIFO_DEPTH = 2;

  typedef enum logic [1:0] {
    RD_IDLE  = 2'd0,
    RD_READ  = 2'd1,
    RD_DRAIN = 2'd2
  } rd_state_e;

endpackage

// File: rtl/sample_buf_ofifo.sv
// Two-entry output FIFO; dout reads zero whenever the FIFO is empty.
module sample_buf_ofifo
  import sample_buf_ctrl_pkg::*;
#(
  parameter int W = 18
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         valid,
  output logic [1:0]   count
);

  logic [W-1:0] mem_r [OFIFO_DEPTH];
  logic         wr_ptr_r;
  logic         rd_ptr_r;
  logic [1:0]   count_r;

  // Storage, pointers and occupancy; the caller never pushes into a full FIFO.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < OFIFO_DEPTH; i++) begin
        mem_r[i] <= {W{1'b0}};
      end
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else begin
      if (push) begin
        mem_r[wr_ptr_r] <= din;
        wr_ptr_r        <= ~wr_ptr_r;
      end
      if (pop) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      case ({push, pop})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  assign valid = (count_r != 2'd0);
  assign dout  = valid ? mem_r[rd_ptr_r] : {W{1'b0}};
  assign count = count_r;

endmodule

// File: rtl/sample_buf_ctrl.sv
// Ping-pong sample buffer controller: fills RAM banks from a sample stream and
// streams full banks out. SAMPLE_BUF_OVF_CNT_EN enables the overflow counter.
module sample_buf_ctrl
  import sample_buf_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              out_bank,
  output logic              mem_cea,
  output logic [ADDR_W-1:0] mem_ada,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_ceb,
  output logic              mem_oce,
  output logic [ADDR_W-1:0] mem_adb,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              ovf,
  input  logic              ovf_clr,
  output logic [15:0]       ovf_count
);

  localparam int OFF_W = ADDR_W - 1;
  localparam logic [OFF_W-1:0] OFF_MAX = {OFF_W{1'b1}};
  localparam logic [OFF_W-1:0] OFF_ONE = {{(OFF_W-1){1'b0}}, 1'b1};

  logic              wbank_r;
  logic [OFF_W-1:0]  woff_r;
  logic [1:0]        full_r;
  logic              rbank_r;
  logic [OFF_W-1:0]  roff_r;
  rd_state_e         state_r;
  logic              mem_cea_r;
  logic [ADDR_W-1:0] mem_ada_r;
  logic [DATA_W-1:0] mem_din_r;
  logic              inflight_r;
  logic              inflight_last_r;
  logic              inflight_bank_r;
  logic              ovf_r;

  logic              wr_ok_s;
  logic              drop_s;
  logic              pop_s;
  logic              release_s;
  logic              rd_en_s;
  logic              room_s;
  logic [2:0]        occ_s;
  logic              fifo_valid_s;
  logic [1:0]        fifo_count_s;
  logic [DATA_W+1:0] fifo_dout_s;

  assign wr_ok_s   = in_valid && !full_r[wbank_r];
  assign drop_s    = in_valid && full_r[wbank_r];
  assign pop_s     = fifo_valid_s && out_ready;
  assign release_s = (state_r == RD_DRAIN) && pop_s && out_last;

  // Read credit: FIFO entries plus the read in flight, crediting this cycle's pop.
  always_comb begin
    occ_s = {1'b0, fifo_count_s} + {2'b00, inflight_r};
    if (occ_s <= (3'd1 + {2'b00, pop_s})) begin
      room_s = 1'b1;
    end else begin
      room_s = 1'b0;
    end
  end

  // Read enable is decoded from current occupancy so a word can issue every cycle.
  assign rd_en_s = (state_r == RD_READ) && room_s && !reset;

  // Write port: registered RAM write strobe, address and data.
  always_ff @(posedge clk) begin
    if (reset) begin
      wbank_r   <= 1'b0;
      woff_r    <= {OFF_W{1'b0}};
      mem_cea_r <= 1'b0;
      mem_ada_r <= {ADDR_W{1'b0}};
      mem_din_r <= {DATA_W{1'b0}};
    end else begin
      mem_cea_r <= wr_ok_s;
      if (wr_ok_s) begin
        mem_ada_r <= {wbank_r, woff_r};
        mem_din_r <= in_data;
        woff_r    <= woff_r + OFF_ONE;
        if (woff_r == OFF_MAX) begin
          wbank_r <= ~wbank_r;
        end
      end
    end
  end

  // Bank full flags: set by the writer on the last offset, cleared on release.
  always_ff @(posedge clk) begin
    if (reset) begin
      full_r <= 2'b00;
    end else begin
      if (wr_ok_s && (woff_r == OFF_MAX)) begin
        full_r[wbank_r] <= 1'b1;
      end
      if (release_s) begin
        full_r[rbank_r] <= 1'b0;
      end
    end
  end

  // Reader FSM plus the one-cycle RAM latency tracking for FIFO capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r         <= RD_IDLE;
      rbank_r         <= 1'b0;
      roff_r          <= {OFF_W{1'b0}};
      inflight_r      <= 1'b0;
      inflight_last_r <= 1'b0;
      inflight_bank_r <= 1'b0;
    end else begin
      inflight_r      <= rd_en_s;
      inflight_last_r <= rd_en_s && (roff_r == OFF_MAX);
      inflight_bank_r <= rbank_r;
      case (state_r)
        RD_IDLE: begin
          if (full_r[rbank_r]) begin
            state_r <= RD_READ;
          end
        end
        RD_READ: begin
          if (rd_en_s) begin
            roff_r <= roff_r + OFF_ONE;
            if (roff_r == OFF_MAX) begin
              state_r <= RD_DRAIN;
            end
          end
        end
        RD_DRAIN: begin
          if (release_s) begin
            state_r <= RD_IDLE;
            rbank_r <= ~rbank_r;
          end
        end
        default: state_r <= RD_IDLE;
      endcase
    end
  end

  sample_buf_ofifo #(
    .W(DATA_W + 2)
  ) u_ofifo (
    .clk   (clk),
    .reset (reset),
    .push  (inflight_r),
    .din   ({inflight_bank_r, inflight_last_r, mem_dout}),
    .pop   (pop_s),
    .dout  (fifo_dout_s),
    .valid (fifo_valid_s),
    .count (fifo_count_s)
  );

  // Sticky overflow flag; a coincident overflow beats the clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_r <= 1'b0;
    end else if (drop_s) begin
      ovf_r <= 1'b1;
    end else if (ovf_clr) begin
      ovf_r <= 1'b0;
    end
  end

`ifdef SAMPLE_BUF_OVF_CNT_EN
  logic [15:0] ovf_count_r;

  // Saturating drop counter, restarting at 1 when a drop meets a clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_count_r <= 16'd0;
    end else if (drop_s) begin
      if (ovf_clr) begin
        ovf_count_r <= 16'd1;
      end else if (ovf_count_r != 16'hFFFF) begin
        ovf_count_r <= ovf_count_r + 16'd1;
      end
    end else if (ovf_clr) begin
      ovf_count_r <= 16'd0;
    end
  end

  assign ovf_count = ovf_count_r;
`else
  assign ovf_count = 16'd0;
`endif

  assign mem_cea   = mem_cea_r;
  assign mem_ada   = mem_ada_r;
  assign mem_din   = mem_din_r;
  assign mem_ceb   = rd_en_s;
  assign mem_adb   = rd_en_s ? {rbank_r, roff_r} : {ADDR_W{1'b0}};
  assign mem_oce   = 1'b1;
  assign out_valid = fifo_valid_s;
  assign out_bank  = fifo_dout_s[DATA_W+1];
  assign out_last  = fifo_dout_s[DATA_W];
  assign out_data  = fifo_dout_s[DATA_W-1:0];
  assign ovf       = ovf_r;

endmodule

// File: tb/tb_sample_buf_ctrl.sv
// Directed bench for sample_buf_ctrl with a RAM model and an output scoreboard.
module tb_sample_buf_ctrl;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_last;
  logic        out_bank;
  logic        mem_cea;
  logic [9:0]  mem_ada;
  logic [15:0] mem_din;
  logic        mem_ceb;
  logic        mem_oce;
  logic [9:0]  mem_adb;
  logic [15:0] mem_dout;
  logic        ovf;
  logic        ovf_clr;
  logic [15:0] ovf_count;

`ifdef SAMPLE_BUF_OVF_CNT_EN
  localparam logic [15:0] CNT_ONE = 16'd1;
  localparam logic [15:0] CNT_TWO = 16'd2;
`else
  localparam logic [15:0] CNT_ONE = 16'd0;
  localparam logic [15:0] CNT_TWO = 16'd0;
`endif

  int          checks = 0;
  int          failures = 0;
  int          pop_cnt = 0;
  logic [17:0] exp_q[$];
  logic        last_banks[$];
  logic [15:0] ram [0:1023];
  logic [15:0] d;
  logic [3:0]  lbp;
  int          lat, n, k, wr, cyc;
  logic        found;

  sample_buf_ctrl dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .out_bank(out_bank), .mem_cea(mem_cea),
    .mem_ada(mem_ada), .mem_din(mem_din), .mem_ceb(mem_ceb),
    .mem_oce(mem_oce), .mem_adb(mem_adb), .mem_dout(mem_dout),
    .ovf(ovf), .ovf_clr(ovf_clr), .ovf_count(ovf_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Simple dual-port RAM, 1-cycle read latency.
  always @(posedge clk) begin
    if (mem_cea) ram[mem_ada] <= mem_din;
    if (mem_ceb) mem_dout <= ram[mem_adb];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: compare every accepted output word against the write-order queue.
  always @(negedge clk) begin
    logic [17:0] exp_w;
    if (out_valid && out_ready) begin
      pop_cnt++;
      check("sb_has_entry", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        exp_w = exp_q.pop_front();
        check("out_word", 32'({out_bank, out_last, out_data}), 32'(exp_w));
      end
      if (out_last) last_banks.push_back(out_bank);
    end
  end

  task automatic drive_write(input logic [15:0] v);
    in_valid = 1'b1;
    in_data  = v;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    last_banks.delete();
    pop_cnt = 0;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = 16'd0; out_ready = 1'b0; ovf_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_mem_cea", 32'(mem_cea), 32'd0);
    check("rst_mem_ceb", 32'(mem_ceb), 32'd0);
    check("rst_mem_oce", 32'(mem_oce), 32'd1);
    check("rst_ovf", 32'({ovf, ovf_count}), 32'd0);
    reset = 1'b0;

    // Single frame, data = offset, sink always ready.
    out_ready = 1'b1;
    for (int i = 0; i < 512; i++) begin
      exp_q.push_back({1'b0, (i == 511), 16'(i)});
      drive_write(16'(i));
    end
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("first_out_latency", 32'(lat), 32'd3);
    n = 0;
    while (out_valid && n < 600) begin
      @(posedge clk); #1;
      n++;
    end
    check("stream_len_1wpc", 32'(n), 32'd512);
    check("frame1_pops", 32'(pop_cnt), 32'd512);
    check("frame1_last_cnt", 32'(last_banks.size()), 32'd1);
    if (last_banks.size() > 0) check("frame1_last_bank", 32'(last_banks[0]), 32'd0);

    // Fill both banks with the sink stalled, then overflow.
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 1024; i++) begin
      exp_q.push_back({1'(i >> 9), ((i % 512) == 511), 16'(i * 3 + 7)});
      drive_write(16'(i * 3 + 7));
    end
    repeat (5) @(posedge clk);
    #1;
    check("stall_head", 32'({out_valid, out_data}), 32'h10007);
    drive_write(16'h7777);
    check("ovf_drop_cea", 32'(mem_cea), 32'd0);
    check("ovf_set", 32'(ovf), 32'd1);
    check("ovf_count_first", 32'(ovf_count), 32'(CNT_ONE));
    ovf_clr = 1'b1;
    @(posedge clk); #1;
    ovf_clr = 1'b0;
    check("ovf_clr", 32'({ovf, ovf_count}), 32'd0);
    ovf_clr = 1'b1;
    drive_write(16'h1111);
    ovf_clr = 1'b0;
    check("ovf_beats_clr", 32'(ovf), 32'd1);
    check("ovf_count_beats_clr", 32'(ovf_count), 32'(CNT_ONE));
    check("ovf_clr_drop_cea", 32'(mem_cea), 32'd0);

    // Release of bank 0 coincides with a sample aimed at bank 0.
    out_ready = 1'b1;
    found = 1'b0;
    k = 0;
    while (!found && k < 2000) begin
      if (out_valid && out_last && !out_bank) found = 1'b1;
      else begin
        @(posedge clk); #1;
        k++;
      end
    end
    check("release_seen", 32'(found), 32'd1);
    drive_write(16'hDEAD);
    check("release_drop_cea", 32'(mem_cea), 32'd0);
    check("release_drop_cnt", 32'(ovf_count), 32'(CNT_TWO));
    drive_write(16'hBEEF);
    check("after_release_cea", 32'(mem_cea), 32'd1);
    check("after_release_addr", 32'(mem_ada), 32'd0);
    check("after_release_din", 32'(mem_din), 32'h0000BEEF);
    k = 0;
    while (exp_q.size() > 0 && k < 2000) begin
      @(posedge clk); #1;
      k++;
    end
    check("bank1_drained", 32'(exp_q.size()), 32'd0);
    check("release_last_cnt", 32'(last_banks.size()), 32'd2);

    // Four frames with random sink readiness and sparse writes.
    do_reset();
    wr = 0;
    cyc = 0;
    while ((wr < 2048 || exp_q.size() > 0) && cyc < 30000) begin
      out_ready = 1'($urandom_range(1, 0));
      if (wr < 2048 && $urandom_range(3, 0) == 0) begin
        d = 16'($urandom);
        exp_q.push_back({1'(wr >> 9), ((wr % 512) == 511), d});
        in_valid = 1'b1;
        in_data  = d;
        wr++;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    check("rand_drained", 32'(exp_q.size()), 32'd0);
    check("rand_pops", 32'(pop_cnt), 32'd2048);
    check("rand_no_ovf", 32'(ovf), 32'd0);
    lbp = 4'd0;
    foreach (last_banks[j]) lbp = {lbp[2:0], last_banks[j]};
    check("rand_bank_order", 32'(lbp), 32'd5);
    check("rand_last_cnt", 32'(last_banks.size()), 32'd4);

    // Reset in the middle of reading a frame.
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 512; i++) begin
      exp_q.push_back({1'b0, (i == 511), 16'(i) ^ 16'h5A5A});
      drive_write(16'(i) ^ 16'h5A5A);
    end
    k = 0;
    while (!(mem_ceb && mem_adb == 10'd100) && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    check("roff100_seen", 32'({mem_ceb, mem_adb}), 32'h464);
    reset = 1'b1;
    @(posedge clk); #1;
    check("midrst_out", 32'({out_valid, out_last, out_bank, out_data}), 32'd0);
    check("midrst_mem_wr", 32'({mem_cea, mem_ada, mem_din}), 32'd0);
    check("midrst_mem_rd", 32'({mem_ceb, mem_adb}), 32'd0);
    check("midrst_oce", 32'(mem_oce), 32'd1);
    check("midrst_ovf", 32'({ovf, ovf_count}), 32'd0);
    reset = 1'b0;
    exp_q.delete();
    last_banks.delete();
    pop_cnt = 0;
    repeat (20) @(posedge clk);
    #1;
    check("no_partial_frame", 32'(pop_cnt), 32'd0);
    for (int i = 0; i < 512; i++) begin
      exp_q.push_back({1'b0, (i == 511), 16'(i) + 16'h0300});
      drive_write(16'(i) + 16'h0300);
    end
    k = 0;
    while (exp_q.size() > 0 && k < 1000) begin
      @(posedge clk); #1;
      k++;
    end
    check("refill_drained", 32'(exp_q.size()), 32'd0);
    check("refill_pops", 32'(pop_cnt), 32'd512);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
